fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage: owns the PC, drives the instruction-memory address and registers the
//  69-bit IF/ID word consumed by decode_stage. After reset it loads the PC from a reset vector in
//  memory, then fetches one 16-bit word per cycle. Stall holds the stage, Flush inserts a NOP,
//  Redirect changes the PC for jumps, calls and returns, and the stage latches an interrupt request.
// PARAMETERS
//  RESET_VEC   32'h0000_0000  word address of vector; PC = {M[RESET_VEC], M[RESET_VEC+1]}
//  NOP_WORD    16'h0000       instruction inserted on flush and during the vector load
// PORTS
//  Clk         in   1   single clock; all state updates on rising edge
//  Rst         in   1   synchronous, active-high reset
//  Stall       in   1   hold PC, Out and FSM (hazard or stall request from decode)
//  Flush       in   1   load NOP into Out this cycle
//  RedirectEn  in   1   load PC from RedirectPC (jump, call, ret, rti)
//  RedirectPC  in   32  redirect target, word address
//  IntReq      in   1   external interrupt request, level-sampled
//  InPort      in   16  input-port value, registered alongside the instruction
//  ImemAddr    out  32  instruction-memory word address; memory read is combinational
//  ImemData    in   16  instruction-memory read data, valid in the same cycle
//  Out         out  69  IF/ID word: [68:53] InPort, [52:21] PC+1 of the fetched word,
//                       [20:5] instruction, [4] interrupt flag, [3:0] reserved, always 0
// BEHAVIOUR
//  - Reset (Rst=1 at edge): state<=VEC_HI, PC<=0, Out<=0, IntPend<=0. This overrides every other input.
//  - FSM has 3 states: VEC_HI -> VEC_LO -> RUN. RUN is terminal until the next Rst.
//    VEC_HI: ImemAddr=RESET_VEC; PC[31:16]<=ImemData.
//    VEC_LO: ImemAddr=RESET_VEC+1; PC[15:0]<=ImemData.
//    While in VEC_HI/VEC_LO: Out holds the NOP word (InPort field=0, PC field=0, instr=NOP_WORD,
//    int flag=0). Stall, Flush and RedirectEn are ignored. IntReq is still latched.
//  - RUN: ImemAddr=PC (combinational from the PC register). Per edge, priority is highest first:
//    1 RedirectEn: PC<=RedirectPC; Out<=NOP word. Applies even when Flush=0; IntPend is kept.
//    2 Flush:      PC<=PC+1; Out<=NOP word; IntPend is kept.
//    3 Stall:      PC, Out and IntPend are held. IntReq is still OR-ed into IntPend.
//    4 normal:     Out<={InPort, PC+1, ImemData, IntPend|IntReq, 4'b0}; PC<=PC+1; IntPend<=0.
//  - Interrupt: IntPend<=IntPend|IntReq on every edge except the normal-load case above. The flag
//    rides on exactly one valid instruction. A request that arrives during stall or flush is never lost.
//  - Latency: word at PC appears on Out 1 cycle after ImemAddr=PC, provided no stall occurs.
//  - PC arithmetic is unsigned 32-bit and wraps from 32'hFFFF_FFFF to 0 without a flag.
//    The PC+1 field uses the same wrap.
//  - Out is a register, with no combinational path from any input to Out.
//  - ImemAddr depends only on the FSM state and the PC register.
//  - Rst asserted mid-RUN or mid-vector restarts the vector load. No partial PC is kept.
// STRUCTURE
//  - Shared package (cpu_pkg) holds:
//    FETCH_OUT_W=69, PC_W=32, INSTR_W=16, and the Out field LSB/MSB constants that decode_stage uses.
//    It also holds NOP_WORD and the fetch state encoding {VEC_HI, VEC_LO, RUN}.
//  - One sub-module: pc_unit (PC register, +1 incrementer, redirect/hold mux, vector-half loads).
//  - The FSM, IntPend and the Out register stay in fetch_stage.
// TESTING
//  1 Reset vector:
//    M[0]=16'h0000, M[1]=16'h0040, Rst pulse -> ImemAddr 0, then 1, then 32'h40.
//    The first real Out has PC field 32'h41 and instr=M[40h]; Out=0 during vector load.
//  2 Stall: Stall=1 for 3 cycles in RUN -> PC and Out are unchanged for 3 cycles.
//    On release, the next word follows without a gap or a duplicate.
//  3 Flush with redirect: Flush=1 and RedirectEn=1 with RedirectPC=32'h200 -> Out instr=NOP_WORD.
//    The next ImemAddr=32'h200, and the following Out holds M[200h] with PC field 32'h201.
//  4 Interrupt under stall: IntReq=1 for 1 cycle while Stall=1 -> after Stall drops, the next
//    loaded Out has bit4=1. The Out after that has bit4=0.
//  5 Wrap: RedirectPC=32'hFFFF_FFFF -> Out PC field=32'h0000_0000 and the next ImemAddr=0.
//  6 Mid-op reset: Rst asserted during a stall with IntPend=1 -> Out=0 and IntPend=0.
//    The vector load repeats (ImemAddr 0,1).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, IF/ID word field positions and fetch state encoding.
package cpu_pkg;

  localparam int unsigned FETCH_OUT_W = 69;
  localparam int unsigned PC_W        = 32;
  localparam int unsigned INSTR_W     = 16;

  // IF/ID word layout, also decoded by decode_stage
  localparam int unsigned OUT_INPORT_MSB = 68;
  localparam int unsigned OUT_INPORT_LSB = 53;
  localparam int unsigned OUT_PC_MSB     = 52;
  localparam int unsigned OUT_PC_LSB     = 21;
  localparam int unsigned OUT_INSTR_MSB  = 20;
  localparam int unsigned OUT_INSTR_LSB  = 5;
  localparam int unsigned OUT_INT_BIT    = 4;

  localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0000;

  typedef enum logic [1:0] {
    VEC_HI,
    VEC_LO,
    RUN
  } fetch_state_e;

  // Bubble word: only the instruction field is non-zero (and only if NOP_WORD is)
  function automatic logic [FETCH_OUT_W-1:0] nop_out(input logic [INSTR_W-1:0] nop);
    logic [FETCH_OUT_W-1:0] w;
    w = '0;
    w[OUT_INSTR_MSB:OUT_INSTR_LSB] = nop;
    return w;
  endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter: register, +1 incrementer, redirect mux and reset-vector half loads.
module pc_unit
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_hi,
  input  logic               load_lo,
  input  logic [INSTR_W-1:0] vec_data,
  input  logic               redirect_en,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               inc,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_inc
);

  logic [PC_W-1:0] pc_q, pc_d;

  // Natural 32-bit wrap from all-ones to zero
  assign pc_inc = pc_q + 32'd1;
  assign pc     = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_hi) begin
      pc_d = {vec_data, pc_q[15:0]};
    end else if (load_lo) begin
      pc_d = {pc_q[31:16], vec_data};
    end else if (redirect_en) begin
      pc_d = redirect_pc;
    end else if (inc) begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: reset-vector load, PC sequencing, interrupt latch and IF/ID register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_VEC = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] NOP_WORD  = cpu_pkg::NOP_WORD
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Stall,
  input  logic                   Flush,
  input  logic                   RedirectEn,
  input  logic [PC_W-1:0]        RedirectPC,
  input  logic                   IntReq,
  input  logic [INSTR_W-1:0]     InPort,
  output logic [PC_W-1:0]        ImemAddr,
  input  logic [INSTR_W-1:0]     ImemData,
  output logic [FETCH_OUT_W-1:0] Out
);

  fetch_state_e           state_q, state_d;
  logic                   int_pend_q, int_pend_d;
  logic [FETCH_OUT_W-1:0] out_q, out_d;

  logic            load_hi, load_lo, redirect, inc;
  logic [PC_W-1:0] pc, pc_inc;

  pc_unit u_pc_unit (
    .clk         (Clk),
    .rst         (Rst),
    .load_hi     (load_hi),
    .load_lo     (load_lo),
    .vec_data    (ImemData),
    .redirect_en (redirect),
    .redirect_pc (RedirectPC),
    .inc         (inc),
    .pc          (pc),
    .pc_inc      (pc_inc)
  );

  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    int_pend_d = int_pend_q | IntReq;
    load_hi    = 1'b0;
    load_lo    = 1'b0;
    redirect   = 1'b0;
    inc        = 1'b0;
    ImemAddr   = pc;
    unique case (state_q)
      VEC_HI: begin
        ImemAddr = RESET_VEC;
        load_hi  = 1'b1;
        out_d    = nop_out(NOP_WORD);
        state_d  = VEC_LO;
      end
      VEC_LO: begin
        ImemAddr = RESET_VEC + 32'd1;
        load_lo  = 1'b1;
        out_d    = nop_out(NOP_WORD);
        state_d  = RUN;
      end
      RUN: begin
        if (RedirectEn) begin
          redirect = 1'b1;
          out_d    = nop_out(NOP_WORD);
        end else if (Flush) begin
          inc   = 1'b1;
          out_d = nop_out(NOP_WORD);
        end else if (!Stall) begin
          // The pending flag is consumed by exactly this one valid instruction
          out_d                               = '0;
          out_d[OUT_INPORT_MSB:OUT_INPORT_LSB] = InPort;
          out_d[OUT_PC_MSB:OUT_PC_LSB]         = pc_inc;
          out_d[OUT_INSTR_MSB:OUT_INSTR_LSB]   = ImemData;
          out_d[OUT_INT_BIT]                   = int_pend_q | IntReq;
          inc                                 = 1'b1;
          int_pend_d                          = 1'b0;
        end
      end
      default: begin
        state_d = VEC_HI;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= VEC_HI;
      out_q      <= '0;
      int_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      int_pend_q <= int_pend_d;
    end
  end

  assign Out = out_q;

endmodule
